// File: rtl/regfile_mp_pkg.sv
// Shared types and write-resolution helper for the multi-port Argon register file.
package regfile_mp_pkg;

  // Index and word types are sized to the widest build we expect;
  // instances narrow or widen into them with size casts.
  localparam int IDX_W_MAX = 8;
  localparam int WORD_W    = 16;

  typedef logic [IDX_W_MAX-1:0] reg_idx_t;
  typedef logic [WORD_W-1:0]    word_t;

  localparam reg_idx_t ZERO_IDX = '0;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_ALU   = 2'd1,
    WR_FLAGS = 2'd2,
    WR_BUS   = 2'd3
  } wr_src_e;

  // Winning write source for register idx: ALU, then flags update, then bus.
  // r0 never accepts a write.
  function automatic wr_src_e resolve_write(
    input reg_idx_t idx,
    input logic     alu_we,
    input reg_idx_t alu_idx,
    input logic     flg_we,
    input reg_idx_t flg_idx,
    input logic     bus_we,
    input reg_idx_t bus_idx
  );
    wr_src_e src;
    src = WR_NONE;
    if (idx == ZERO_IDX)                 src = WR_NONE;
    else if (alu_we && alu_idx == idx)   src = WR_ALU;
    else if (flg_we && flg_idx == idx)   src = WR_FLAGS;
    else if (bus_we && bus_idx == idx)   src = WR_BUS;
    return src;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by a
// landed write; a same-cycle reserve beats the clear. Bit 0 is never set.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [NUM_REGS-1:0] set_i,
  input  logic [NUM_REGS-1:0] clr_i,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear first, then OR in reservations so reserve wins on a collision.
  always_comb begin
    pending_d    = (pending_q & ~clr_i) | set_i;
    pending_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/argon_regfile_mp.sv
// Multi-port Argon register file: latched read selectors, prioritised ALU /
// flags / bus writes, sticky r0-write error and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read
// ports and o_flags.
module argon_regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RD     = 2,
  parameter int FLAGS_IDX  = NUM_REGS - 1,
  localparam int IW        = $clog2(NUM_REGS)
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset,
  input  logic                         i_sel_we,
  input  logic [(NUM_RD+1)*IW-1:0]     i_sel_data,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_pending,
  input  logic                         i_alu_we,
  input  logic [DATA_WIDTH-1:0]        i_alu_data,
  input  logic                         i_bus_we,
  input  logic [IW-1:0]                i_bus_addr,
  input  logic [DATA_WIDTH-1:0]        i_bus_data,
  input  logic                         i_flags_we,
  input  logic [DATA_WIDTH-1:0]        i_flags_mask,
  input  logic [DATA_WIDTH-1:0]        i_flags_data,
  input  logic                         i_reserve,
  output logic [NUM_REGS-1:0]          o_pending,
  output logic [DATA_WIDTH-1:0]        o_flags,
  output logic                         o_err,
  input  logic                         i_err_clr
);

  logic [NUM_RD:0][IW-1:0]             sel_q, sel_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d, wr_data;
  logic [NUM_REGS-1:0]                 wr_we, rsv_set, pending;
  logic [IW-1:0]                       sel_dst;
  logic [DATA_WIDTH-1:0]               flags_merged;
  logic                                err_q, err_d;

  // Top selector field is the destination for ALU writes and reservations.
  assign sel_dst      = sel_q[NUM_RD];
  assign flags_merged = (regs_q[FLAGS_IDX] & ~i_flags_mask) | (i_flags_data & i_flags_mask);

  // Per-register write arbitration: one winning source per register.
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_wr
    wr_src_e src;
    assign src = resolve_write(reg_idx_t'(n), i_alu_we, reg_idx_t'(sel_dst),
                               i_flags_we, reg_idx_t'(FLAGS_IDX),
                               i_bus_we, reg_idx_t'(i_bus_addr));
    assign wr_we[n]   = (src != WR_NONE);
    assign wr_data[n] = (src == WR_ALU)   ? i_alu_data   :
                        (src == WR_FLAGS) ? flags_merged : i_bus_data;
  end

  // Next state of storage, selectors and sticky error.
  always_comb begin
    regs_d = regs_q;
    for (int n = 0; n < NUM_REGS; n++)
      if (wr_we[n]) regs_d[n] = wr_data[n];
    regs_d[0] = '0;
    sel_d = i_sel_we ? i_sel_data : sel_q;
    // Set has priority over clear.
    err_d = (err_q & ~i_err_clr) | (i_bus_we && i_bus_addr == '0);
  end

  // One-hot reservation of the current destination; r0 reservations are dropped.
  always_comb begin
    rsv_set = '0;
    if (i_reserve && sel_dst != '0) rsv_set[sel_dst] = 1'b1;
  end

  // Storage, selector and error registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      regs_q <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .set_i     (rsv_set),
    .clr_i     (wr_we),
    .pending_o (pending)
  );

  // Read ports; r0 storage is always zero so selector 0 reads 0.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [IW-1:0] s;
    assign s = sel_q[k];
`ifdef REGFILE_BYPASS_EN
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_we[s] ? wr_data[s] : regs_q[s];
    assign o_rd_pending[k] = pending[s] & ~wr_we[s];
`else
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[s];
    assign o_rd_pending[k] = pending[s];
`endif
  end

`ifdef REGFILE_BYPASS_EN
  assign o_flags = wr_we[FLAGS_IDX] ? wr_data[FLAGS_IDX] : regs_q[FLAGS_IDX];
`else
  assign o_flags = regs_q[FLAGS_IDX];
`endif

  assign o_pending = pending;
  assign o_err     = err_q;

endmodule

// File: tb/tb_argon_regfile_mp.sv
// Directed self-checking bench for argon_regfile_mp (default parameters).
module tb_argon_regfile_mp;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int NRD = 2;
  localparam int IW = 3;

  logic              i_Clk = 1'b0;
  logic              i_Reset;
  logic              i_sel_we;
  logic [(NRD+1)*IW-1:0] i_sel_data;
  logic [NRD*DW-1:0] o_rd_data;
  logic [NRD-1:0]    o_rd_pending;
  logic              i_alu_we;
  logic [DW-1:0]     i_alu_data;
  logic              i_bus_we;
  logic [IW-1:0]     i_bus_addr;
  logic [DW-1:0]     i_bus_data;
  logic              i_flags_we;
  logic [DW-1:0]     i_flags_mask;
  logic [DW-1:0]     i_flags_data;
  logic              i_reserve;
  logic [NR-1:0]     o_pending;
  logic [DW-1:0]     o_flags;
  logic              o_err;
  logic              i_err_clr;

  int checks = 0;
  int errors = 0;

  argon_regfile_mp dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_sel_we     (i_sel_we),
    .i_sel_data   (i_sel_data),
    .o_rd_data    (o_rd_data),
    .o_rd_pending (o_rd_pending),
    .i_alu_we     (i_alu_we),
    .i_alu_data   (i_alu_data),
    .i_bus_we     (i_bus_we),
    .i_bus_addr   (i_bus_addr),
    .i_bus_data   (i_bus_data),
    .i_flags_we   (i_flags_we),
    .i_flags_mask (i_flags_mask),
    .i_flags_data (i_flags_data),
    .i_reserve    (i_reserve),
    .o_pending    (o_pending),
    .o_flags      (o_flags),
    .o_err        (o_err),
    .i_err_clr    (i_err_clr)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle();
    i_sel_we = 0; i_alu_we = 0; i_bus_we = 0; i_flags_we = 0;
    i_reserve = 0; i_err_clr = 0;
  endtask

  task automatic set_sel(input logic [IW-1:0] s0, input logic [IW-1:0] s1, input logic [IW-1:0] sd);
    i_sel_data = {sd, s1, s0};
    i_sel_we = 1;
    tick();
    i_sel_we = 0;
  endtask

  task automatic test_reset();
    i_Reset = 1;
    tick(); tick();
    i_Reset = 0;
    tick();
    checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want %h", o_rd_data, 32'h0); end
    checks++; if (o_pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want %h", o_pending, 8'h00); end
    checks++; if (o_flags !== 16'h0) begin errors++; $display("FAIL reset_flags: got %h want %h", o_flags, 16'h0); end
    checks++; if (o_err !== 1'b0 || o_rd_pending !== 2'b00) begin errors++; $display("FAIL reset_err: got err=%b rdp=%b want 0/00", o_err, o_rd_pending); end
  endtask

  task automatic test_alu_write();
    set_sel(3'd1, 3'd2, 3'd3);
    i_alu_we = 1; i_alu_data = 16'hBEEF;
    tick();
    idle();
    checks++; if (o_rd_data !== 32'h0000_0000) begin errors++; $display("FAIL alu_ports_r1r2: got %h want %h", o_rd_data, 32'h0); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL alu_no_err: got %b want 0", o_err); end
    set_sel(3'd3, 3'd3, 3'd3);
    checks++; if (o_rd_data !== 32'hBEEF_BEEF) begin errors++; $display("FAIL alu_r3: got %h want %h", o_rd_data, 32'hBEEF_BEEF); end
  endtask

  task automatic test_priority();
    set_sel(3'd4, 3'd5, 3'd4);
    i_alu_we = 1; i_alu_data = 16'h1111;
    i_bus_we = 1; i_bus_addr = 3'd4; i_bus_data = 16'h2222;
    tick();
    idle();
    checks++; if (o_rd_data[15:0] !== 16'h1111) begin errors++; $display("FAIL prio_alu_over_bus: got %h want %h", o_rd_data[15:0], 16'h1111); end
    i_alu_we = 1; i_alu_data = 16'h3333;
    i_bus_we = 1; i_bus_addr = 3'd5; i_bus_data = 16'h4444;
    tick();
    idle();
    checks++; if (o_rd_data !== 32'h4444_3333) begin errors++; $display("FAIL prio_both_land: got %h want %h", o_rd_data, 32'h4444_3333); end
  endtask

  task automatic test_flags();
    set_sel(3'd7, 3'd0, 3'd7);
    i_bus_we = 1; i_bus_addr = 3'd7; i_bus_data = 16'h00F0;
    tick();
    idle();
    checks++; if (o_flags !== 16'h00F0) begin errors++; $display("FAIL flags_bus_full: got %h want %h", o_flags, 16'h00F0); end
    i_flags_we = 1; i_flags_mask = 16'h000F; i_flags_data = 16'h0005;
    i_bus_we = 1; i_bus_addr = 3'd7; i_bus_data = 16'hFFFF;
    tick();
    idle();
    checks++; if (o_flags !== 16'h00F5) begin errors++; $display("FAIL flags_mask_over_bus: got %h want %h", o_flags, 16'h00F5); end
    i_alu_we = 1; i_alu_data = 16'h1234;
    i_flags_we = 1; i_flags_mask = 16'hFFFF; i_flags_data = 16'h0000;
    tick();
    idle();
    checks++; if (o_flags !== 16'h1234) begin errors++; $display("FAIL flags_alu_over_update: got %h want %h", o_flags, 16'h1234); end
    checks++; if (o_rd_data !== 32'h0000_1234) begin errors++; $display("FAIL flags_ports: got %h want %h", o_rd_data, 32'h0000_1234); end
  endtask

  task automatic test_scoreboard();
    set_sel(3'd6, 3'd1, 3'd6);
    i_reserve = 1;
    tick();
    idle();
    checks++; if (o_pending !== 8'h40) begin errors++; $display("FAIL sb_reserve: got %h want %h", o_pending, 8'h40); end
    checks++; if (o_rd_pending !== 2'b01) begin errors++; $display("FAIL sb_rd_pending: got %b want %b", o_rd_pending, 2'b01); end
    i_bus_we = 1; i_bus_addr = 3'd6; i_bus_data = 16'hAAAA;
    tick();
    idle();
    checks++; if (o_pending !== 8'h00 || o_rd_pending !== 2'b00) begin errors++; $display("FAIL sb_clear: got %h/%b want 00/00", o_pending, o_rd_pending); end
    checks++; if (o_rd_data[15:0] !== 16'hAAAA) begin errors++; $display("FAIL sb_write_data: got %h want %h", o_rd_data[15:0], 16'hAAAA); end
    i_reserve = 1; i_alu_we = 1; i_alu_data = 16'hBBBB;
    tick();
    idle();
    checks++; if (o_pending !== 8'h40) begin errors++; $display("FAIL sb_reserve_wins: got %h want %h", o_pending, 8'h40); end
    checks++; if (o_rd_data[15:0] !== 16'hBBBB) begin errors++; $display("FAIL sb_rsv_write_data: got %h want %h", o_rd_data[15:0], 16'hBBBB); end
    set_sel(3'd6, 3'd1, 3'd0);
    i_reserve = 1;
    tick();
    idle();
    checks++; if (o_pending !== 8'h40) begin errors++; $display("FAIL sb_r0_reserve: got %h want %h", o_pending, 8'h40); end
  endtask

  task automatic test_err();
    i_bus_we = 1; i_bus_addr = 3'd0; i_bus_data = 16'h5555;
    tick();
    idle();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", o_err); end
    i_err_clr = 1; i_bus_we = 1; i_bus_addr = 3'd0; i_bus_data = 16'h5555;
    tick();
    idle();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", o_err); end
    i_err_clr = 1;
    tick();
    idle();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", o_err); end
    set_sel(3'd0, 3'd0, 3'd0);
    checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL err_r0_zero: got %h want %h", o_rd_data, 32'h0); end
  endtask

  task automatic test_reset_mid();
    set_sel(3'd6, 3'd7, 3'd2);
    i_reserve = 1;
    tick();
    idle();
    i_bus_we = 1; i_bus_addr = 3'd0; i_bus_data = 16'h0001;
    tick();
    idle();
    checks++; if (o_pending !== 8'h44 || o_err !== 1'b1 || o_rd_data !== 32'h1234_BBBB) begin
      errors++; $display("FAIL mid_prestate: got p=%h e=%b rd=%h want 44/1/1234bbbb", o_pending, o_err, o_rd_data);
    end
    i_alu_we = 1; i_alu_data = 16'h9999; i_reserve = 1;
    #2 i_Reset = 1;
    #1;
    checks++; if (o_pending !== 8'h00 || o_rd_pending !== 2'b00) begin errors++; $display("FAIL mid_pending: got %h/%b want 00/00", o_pending, o_rd_pending); end
    checks++; if (o_rd_data !== 32'h0 || o_flags !== 16'h0) begin errors++; $display("FAIL mid_data: got rd=%h fl=%h want 0/0", o_rd_data, o_flags); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", o_err); end
    tick();
    idle();
    i_Reset = 0;
    tick();
    set_sel(3'd2, 3'd6, 3'd2);
    checks++; if (o_rd_data !== 32'h0 || o_pending !== 8'h00) begin errors++; $display("FAIL mid_discard: got rd=%h p=%h want 0/00", o_rd_data, o_pending); end
  endtask

`ifdef REGFILE_BYPASS_EN
  task automatic test_bypass();
    set_sel(3'd3, 3'd0, 3'd3);
    i_reserve = 1;
    tick();
    idle();
    i_alu_we = 1; i_alu_data = 16'h7777;
    #1;
    checks++; if (o_rd_data[15:0] !== 16'h7777) begin errors++; $display("FAIL byp_data: got %h want %h", o_rd_data[15:0], 16'h7777); end
    checks++; if (o_rd_pending !== 2'b00) begin errors++; $display("FAIL byp_pending_mask: got %b want 00", o_rd_pending); end
    tick();
    idle();
  endtask
`endif

  initial begin
    i_Reset = 0; i_sel_data = '0; i_alu_data = '0; i_bus_addr = '0; i_bus_data = '0;
    i_flags_mask = '0; i_flags_data = '0;
    idle();
    test_reset();
    test_alu_write();
    test_priority();
    test_flags();
    test_scoreboard();
    test_err();
    test_reset_mid();
`ifdef REGFILE_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/argon_regfile_mp.md
# argon_regfile_mp

Parametrised multi-port successor to the Argon register file. It holds NUM_REGS words of DATA_WIDTH bits: r0 is hard-wired zero and FLAGS_IDX is the flags register. It provides NUM_RD latched-selector read ports, two prioritised write ports (ALU and bus) and a masked flags-update port. A pending-write scoreboard lets the control unit stall on registers with an outstanding write.

## Interface
- DATA_WIDTH, 16, word width in bits
- NUM_REGS, 8, register count including r0; power of two, ≥ 4
- NUM_RD, 2, number of read ports, 1..4
- FLAGS_IDX, NUM_REGS-1, index of the flags register; must be non-zero
- i_Clk  input  1  clock, rising edge
- i_Reset  input  1  reset i_Reset, asynchronous, active-high; clock i_Clk
- i_sel_we  input  1  latch new read selectors and destination selector
- i_sel_data  input  (NUM_RD+1)*IW  field k (k < NUM_RD) is the selector for read port k; top field is selD; IW = $clog2(NUM_REGS)
- o_rd_data  output  NUM_RD*DATA_WIDTH  read data per port, field k is port k
- o_rd_pending  output  NUM_RD  port k selects a register with a pending write
- i_alu_we  input  1  write port 0 (ALU) enable; target is selD
- i_alu_data  input  DATA_WIDTH  port 0 write data
- i_bus_we  input  1  write port 1 (bus) enable
- i_bus_addr  input  IW  port 1 target register
- i_bus_data  input  DATA_WIDTH  port 1 write data
- i_flags_we  input  1  masked flags update enable
- i_flags_mask  input  DATA_WIDTH  bits of the flags register to update
- i_flags_data  input  DATA_WIDTH  new flag bits
- i_reserve  input  1  mark selD pending; uses the selD value in effect this cycle
- o_pending  output  NUM_REGS  scoreboard vector; bit 0 is always 0
- o_flags  output  DATA_WIDTH  current flags register value
- o_err  output  1  sticky error: a bus write was attempted to r0
- i_err_clr  input  1  clear o_err

## Operation
- Reads are combinational from the latched selectors selK. A selector of 0 returns 0. o_rd_pending[k] = o_pending[selK].
- i_sel_we updates all selectors at the clock edge. Reads use the new selectors from the next cycle.
- Write priority for the same register in the same cycle: ALU port, then flags update, then bus port. Only the highest-priority write lands; writes to different registers all land.
- A flags update writes (F & ~mask) | (data & mask). An ALU or bus write to FLAGS_IDX writes the full word.
- Writes to r0 are dropped. A bus write to r0 sets o_err; an ALU write to r0 does not.
- Scoreboard:
  - i_reserve with selD ≠ 0 sets o_pending[selD].
  - Any landed write to register n clears o_pending[n].
  - If reserve and a write hit the same register in the same cycle, the reserve wins and the bit stays set.
  - A reserve of r0 is ignored.
- Error: o_err is set by a bus write to r0. If i_err_clr and a set condition occur in the same cycle, the set wins.
- Reset:
  - All registers, selectors, o_pending and o_err go to 0.
  - o_rd_data, o_rd_pending and o_flags are therefore 0.
  - Reset asserted mid-operation discards in-flight writes and reservations immediately; there is no recovery of prior state.

## Timing
- Write latency is 1 cycle: data presented at edge t is readable after edge t, unless bypass is enabled (see Configuration).
- Selector latch latency is 1 cycle. i_alu_we in the same cycle as i_sel_we targets the old selD.
- The scoreboard updates at the clock edge; o_pending and o_rd_pending are valid after the edge.
- There is no backpressure: every enable is accepted in the cycle it is asserted.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Each read port forwards same-cycle write data when the write targets its selected register, using the same priority (ALU, flags-merged value, bus).
  - o_flags forwards likewise.
  - o_rd_pending[k] is masked to 0 when a same-cycle write to selK is forwarded.
- REGFILE_BYPASS_EN undefined: reads return only the stored values; there is no combinational path from write inputs to read outputs.

## Structure
- Shared package regfile_mp_pkg holds:
  - the reg_idx_t and word typedefs;
  - the ZERO_IDX constant;
  - a write-resolve function that returns the winning write for a register index.
- Sub-module regfile_scoreboard: the NUM_REGS-bit pending vector with reserve/clear logic, instantiated once.
- The top level holds the storage array, selectors, write arbitration, the optional bypass and the error flag.

## Test plan
- Reset, then latch sel0=1, sel1=2, selD=3; ALU writes 0xBEEF → port 0 and port 1 read 0 and register 3 reads 0xBEEF next cycle; o_err=0.
- In the same cycle, ALU writes 0x1111 to selD=4 and bus writes 0x2222 to register 4 → register 4 = 0x1111. Bus write to 5 alongside ALU to 4 → both land.
- Flags: F=0x00F0; flags update with mask 0x000F, data 0x0005 → F=0x00F5. In the same cycle as a bus write of 0xFFFF to FLAGS_IDX → F=0x00F5.
- Scoreboard:
  - Reserve selD=6 → o_pending[6]=1; o_rd_pending is set on a port selecting 6.
  - A bus write to 6 clears the bit.
  - Reserve and write to 6 in the same cycle → the bit stays 1.
- Bus write to r0 → r0 still reads 0 and o_err=1. i_err_clr with a simultaneous bus write to r0 → o_err stays 1. i_err_clr alone → 0.
- Asserting reset mid-sequence with pending bits set → everything is 0 asynchronously. With REGFILE_BYPASS_EN, an ALU write to a selected register reads the new data in the same cycle.
